pipeline_stall_controller: RTL and testbench

Central stall/flush scheduler for the 5-stage MIPS pipeline. It sits beside the decode stage and generates every hold, bubble and flush for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three sources: load-use and branch-operand hazards with multi-cycle stall sequencing, taken-branch flushes, and a variable-latency data-memory handshake with a timeout.

---
 rtl/pipeline_stall_controller_if.sv | 20 ++
 rtl/pipeline_stall_controller.sv | 101 ++++++++++
 tb/tb_pipeline_stall_controller.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_controller_if.sv
// pipeline_stall_controller_if: hazard/handshake inputs (master drives) and hold/bubble/flush/counter outputs (slave drives) of the stall controller
interface pipeline_stall_controller_if;
  logic [4:0] id_rs, id_rt, idex_wr_reg, exme_wr_reg;
  logic id_uses_rt, id_is_branch, id_branch_taken;
  logic idex_mem_read, idex_reg_write, exme_mem_read, exme_mem_req, dmem_ready;
  logic pc_hold, ifid_hold, ifid_flush, idex_bubble, idex_hold, exme_hold, memwb_bubble, mem_timeout;
  logic [31:0] stall_cycles, flush_count;
  modport master(
    output id_rs, id_rt, id_uses_rt, id_is_branch, id_branch_taken, idex_mem_read, idex_reg_write,
           idex_wr_reg, exme_mem_read, exme_wr_reg, exme_mem_req, dmem_ready,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble, idex_hold, exme_hold, memwb_bubble,
           mem_timeout, stall_cycles, flush_count
  );
  modport slave(
    input  id_rs, id_rt, id_uses_rt, id_is_branch, id_branch_taken, idex_mem_read, idex_reg_write,
           idex_wr_reg, exme_mem_read, exme_wr_reg, exme_mem_req, dmem_ready,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble, idex_hold, exme_hold, memwb_bubble,
           mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: 5-stage pipeline stall/flush scheduler (ports: clk, rst_n sync active-low, s = pipeline_stall_controller_if.slave; STALL_PERF_CNT_EN builds the stall/flush perf counters)
module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT = 255
) (
  input logic clk,
  input logic rst_n,
  pipeline_stall_controller_if.slave s
);
  typedef enum logic [1:0] {RUN, STALL, MEM_WAIT, ERROR} state_t;
  state_t state_q, state_d, ret_q, ret_d, eff;
  logic [1:0] stall_left_q, stall_left_d, n;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic mem_timeout_q, mem_timeout_d;
  logic dep_ex, dep_mem, mw, freeze, bubble, flush;
  assign dep_ex = s.idex_wr_reg != 5'd0 && (s.idex_wr_reg == s.id_rs || (s.id_uses_rt && s.idex_wr_reg == s.id_rt));
  assign dep_mem = s.exme_wr_reg != 5'd0 && (s.exme_wr_reg == s.id_rs || (s.id_uses_rt && s.exme_wr_reg == s.id_rt));
  assign mw = s.exme_mem_req && !s.dmem_ready;
  assign n = (s.idex_mem_read && dep_ex) ? (s.id_is_branch ? 2'd2 : 2'd1) :
             (s.id_is_branch && ((s.idex_reg_write && dep_ex) || (s.exme_mem_read && dep_mem))) ? 2'd1 : 2'd0;
  always_comb begin
    eff = (state_q == MEM_WAIT && s.dmem_ready) ? ret_q : state_q;
    freeze = 1'b0;
    bubble = 1'b0;
    flush = 1'b0;
    state_d = state_q;
    ret_d = ret_q;
    stall_left_d = stall_left_q;
    wait_cnt_d = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    if (state_q == ERROR) begin
      freeze = 1'b1;
    end else if (state_q == MEM_WAIT && !s.dmem_ready) begin
      freeze = 1'b1;
      wait_cnt_d = wait_cnt_q + 8'd1;
      if (wait_cnt_q == 8'(MEM_TIMEOUT)) begin
        mem_timeout_d = 1'b1;
        state_d = ERROR;
      end
    end else if (mw) begin
      freeze = 1'b1;
      ret_d = state_q;
      wait_cnt_d = 8'd1;
      state_d = MEM_WAIT;
    end else if (eff == STALL) begin
      bubble = 1'b1;
      stall_left_d = stall_left_q - 2'd1;
      state_d = (stall_left_q == 2'd1) ? RUN : STALL;
    end else if (n != 2'd0) begin
      bubble = 1'b1;
      stall_left_d = n - 2'd1;
      state_d = (n == 2'd2) ? STALL : RUN;
    end else begin
      flush = s.id_branch_taken;
      state_d = RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      ret_q <= RUN;
      stall_left_q <= 2'd0;
      wait_cnt_q <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q <= ret_d;
      stall_left_q <= stall_left_d;
      wait_cnt_q <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end
  assign s.pc_hold = freeze || bubble;
  assign s.ifid_hold = freeze || bubble;
  assign s.ifid_flush = flush;
  assign s.idex_bubble = bubble;
  assign s.idex_hold = freeze;
  assign s.exme_hold = freeze;
  assign s.memwb_bubble = freeze;
  assign s.mem_timeout = mem_timeout_q;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d, flush_count_q, flush_count_d;
  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, freeze || bubble};
    flush_count_d = flush_count_q + {31'd0, flush};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q <= flush_count_d;
    end
  end
  assign s.stall_cycles = stall_cycles_q;
  assign s.flush_count = flush_count_q;
`else
  assign s.stall_cycles = 32'd0;
  assign s.flush_count = 32'd0;
`endif
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: randomized + directed scoreboard bench for pipeline_stall_controller
module tb_pipeline_stall_controller;
  localparam int T = 4;
  typedef struct packed {
    logic [4:0] rs, rt;
    logic uses_rt, br, taken, ld, rw;
    logic [4:0] wr;
    logic mld;
    logic [4:0] mwr;
    logic req, rdy;
  } stim_t;
  typedef struct {
    logic [7:0] ctl;
    logic [31:0] sc, fc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  exp_t e;
  int pending, waited;
  bit waiting, err;
  logic [31:0] m_sc, m_fc;
  pipeline_stall_controller_if bus();
  pipeline_stall_controller #(.MEM_TIMEOUT(T)) dut (.clk(clk), .rst_n(rst_n), .s(bus.slave));
  always #5 clk = ~clk;
  function automatic int hz(stim_t t);
    bit dx = t.wr != 0 && (t.wr == t.rs || (t.uses_rt && t.wr == t.rt));
    bit dm = t.mwr != 0 && (t.mwr == t.rs || (t.uses_rt && t.mwr == t.rt));
    if (t.ld && dx) return t.br ? 2 : 1;
    return (t.br && ((t.rw && dx) || (t.mld && dm))) ? 1 : 0;
  endfunction
  task automatic apply(stim_t t);
    bus.id_rs = t.rs; bus.id_rt = t.rt; bus.id_uses_rt = t.uses_rt;
    bus.id_is_branch = t.br; bus.id_branch_taken = t.taken;
    bus.idex_mem_read = t.ld; bus.idex_reg_write = t.rw; bus.idex_wr_reg = t.wr;
    bus.exme_mem_read = t.mld; bus.exme_wr_reg = t.mwr;
    bus.exme_mem_req = t.req; bus.dmem_ready = t.rdy;
  endtask
  // Model: owed bubbles, a freeze while memory is outstanding, and a sticky error.
  task automatic step(stim_t t);
    bit f = 0, b = 0, fl = 0, go = 1, err_next;
    int nn;
    exp_t x;
    @(posedge clk); #1;
    apply(t);
    err_next = err;
    if (err) begin
      f = 1; go = 0;
    end else if (waiting) begin
      if (!t.rdy) begin
        f = 1; go = 0; waited++;
        if (waited == T) err_next = 1;
      end else waiting = 0;
    end
    if (go) begin
      if (t.req && !t.rdy) begin
        f = 1; waiting = 1; waited = 0;
      end else if (pending > 0) begin
        b = 1; pending--;
      end else begin
        nn = hz(t);
        if (nn > 0) begin b = 1; pending = nn - 1; end
        else fl = t.taken;
      end
    end
    x.ctl = {f | b, f | b, fl, b, f, f, f, err};
`ifdef STALL_PERF_CNT_EN
    x.sc = m_sc; x.fc = m_fc;
`else
    x.sc = 0; x.fc = 0;
`endif
    exp_q.push_back(x);
    m_sc += 32'(f | b);
    m_fc += 32'(fl);
    err = err_next;
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    apply('0);
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    pending = 0; waiting = 0; waited = 0; err = 0; m_sc = 0; m_fc = 0;
  endtask
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks += 2;
      if ({bus.pc_hold, bus.ifid_hold, bus.ifid_flush, bus.idex_bubble, bus.idex_hold,
           bus.exme_hold, bus.memwb_bubble, bus.mem_timeout} !== e.ctl) begin
        failures++;
        $display("FAIL ctl t=%0t got=%b want=%b (pc,ifid_h,flush,idex_b,idex_h,exme_h,memwb_b,tmo)",
                 $time, {bus.pc_hold, bus.ifid_hold, bus.ifid_flush, bus.idex_bubble, bus.idex_hold,
                 bus.exme_hold, bus.memwb_bubble, bus.mem_timeout}, e.ctl);
      end
      if (bus.stall_cycles !== e.sc || bus.flush_count !== e.fc) begin
        failures++;
        $display("FAIL cnt t=%0t got=%0d/%0d want=%0d/%0d", $time, bus.stall_cycles, bus.flush_count, e.sc, e.fc);
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    stim_t t;
    logic [27:0] r;
    apply('0);
    do_reset();
    step('0);
    t = '0; t.ld = 1; t.rw = 1; t.wr = 2; t.rs = 2; t.rt = 4; t.uses_rt = 1;
    step(t);
    t.ld = 0; t.rw = 0; t.wr = 0; t.mld = 1; t.mwr = 2;
    step(t);
    step('0);
    t = '0; t.ld = 1; t.rw = 1; t.wr = 2; t.rs = 2; t.rt = 5; t.uses_rt = 1; t.br = 1; t.taken = 1;
    step(t);
    t.ld = 0; t.rw = 0; t.wr = 0; t.mld = 1; t.mwr = 2; t.req = 1; t.rdy = 1;
    step(t);
    t.mld = 0; t.mwr = 0; t.req = 0;
    step(t);
    step('0);
    t = '0; t.req = 1;
    repeat (3) step(t);
    t.rdy = 1;
    step(t);
    step('0);
    t = '0; t.ld = 1; t.rw = 1; t.wr = 3; t.rs = 3; t.br = 1;
    step(t);
    t = '0; t.req = 1;
    repeat (2) step(t);
    t.rdy = 1;
    step(t);
    step('0);
    step('0);
    t = '0; t.ld = 1; t.rw = 1; t.wr = 0; t.rs = 0; t.br = 1; t.taken = 1;
    step(t);
    t = '0; t.req = 1;
    repeat (8) step(t);
    t.rdy = 1;
    step(t);
    do_reset();
    step('0);
    for (int p = 0; p < 30; p++) begin
      for (int c = 0; c < 60; c++) begin
        r = 28'($urandom);
        t = r;
        t.rs = 5'($urandom_range(0, 3)); t.rt = 5'($urandom_range(0, 3));
        t.wr = 5'($urandom_range(0, 3)); t.mwr = 5'($urandom_range(0, 3));
        t.taken = t.br && t.taken;
        t.req = ($urandom_range(0, 9) < 3);
        t.rdy = ($urandom_range(0, 9) < 6);
        step(t);
      end
      do_reset();
    end
    @(posedge clk); @(posedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
